spi_frame_scheduler: RTL

Command/response scheduler directly upstream of `spi_master`. Buffers outgoing words in a small FIFO and launches one SPI frame per word via `st`/`din`. Detects frame completion from the master's `load` output and returns the received `dout` word on a valid/ready response port. Enforces a programmable inter-frame gap and a completion watchdog.

---
 rtl/spi_frame_scheduler_pkg.sv | 20 ++
 rtl/spi_frame_scheduler_if.sv | 27 ++
 rtl/spi_frame_scheduler_fifo.sv | 61 ++++++
 rtl/spi_frame_scheduler.sv | 119 +++++++++++
 4 files changed

// File: rtl/spi_frame_scheduler_pkg.sv
// Shared types and constants for the SPI frame scheduler and its master.
package spi_ctrl_pkg;

  localparam int SPI_WIDTH = 13;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    CAPTURE,
    GAP
  } state_t;

  // Bits needed to hold any value 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/spi_frame_scheduler_if.sv
// Command, response and master-facing signals of the SPI frame scheduler.
interface spi_frame_scheduler_if
  import spi_ctrl_pkg::*;
#(
  parameter int WIDTH = SPI_WIDTH
);
  logic [WIDTH-1:0] cmd_data;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             spi_st;
  logic [WIDTH-1:0] spi_din;
  logic             spi_load;
  logic [WIDTH-1:0] spi_dout;

  modport slave (
    input  cmd_data, cmd_valid, rsp_ready, spi_load, spi_dout,
    output cmd_ready, rsp_data, rsp_valid, spi_st, spi_din
  );

  modport master (
    output cmd_data, cmd_valid, rsp_ready, spi_load, spi_dout,
    input  cmd_ready, rsp_data, rsp_valid, spi_st, spi_din
  );
endinterface

// File: rtl/spi_frame_scheduler_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO is dropped even with a pop.
module sync_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push_ok, pop_ok;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];
  assign level   = level_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end
endmodule

// File: rtl/spi_frame_scheduler.sv
// Queues command words, launches one spi_master frame per word and returns the
// received word; enforces an inter-frame gap and a completion watchdog.
module spi_frame_scheduler
  import spi_ctrl_pkg::*;
#(
  parameter int WIDTH          = SPI_WIDTH,
  parameter int DEPTH          = 4,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 65535,
  localparam int LVL_W         = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spi_frame_scheduler_if.slave bus,
  input  logic                 clr_err,
  output logic                 busy,
  output logic                 timeout_err,
  output logic [LVL_W-1:0]     level
);
  localparam int WDOG_W = cnt_width(TIMEOUT_CYCLES);
  localparam int GAP_W  = cnt_width(GAP_CYCLES);

  state_t           state_q, state_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              terr_q, terr_d;
  logic              pop, full, empty, slot_free, wdog_expired;
  logic [WIDTH-1:0]  head;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.cmd_valid),
    .pop   (pop),
    .din   (bus.cmd_data),
    .head  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign bus.cmd_ready = !full;
  assign bus.spi_st    = (state_q == START);
  assign bus.spi_din   = head;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign timeout_err   = terr_q;
  assign busy          = (state_q != IDLE) || (level != '0);

  assign slot_free    = !rsp_valid_q || bus.rsp_ready;
  assign wdog_expired = (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d     = state_q;
    wdog_d      = wdog_q;
    gap_d       = gap_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    terr_d      = terr_q;
    pop         = 1'b0;
    if (rsp_valid_q && bus.rsp_ready) rsp_valid_d = 1'b0;
    if (clr_err) terr_d = 1'b0;
    case (state_q)
      IDLE: begin
        // spi_load gating keeps a master frame left over from reset unobserved
        if (!empty && bus.spi_load && slot_free) state_d = START;
      end
      START: begin
        wdog_d  = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY, WAIT_DONE: begin
        wdog_d = wdog_q + 1'b1;
        if ((state_q == WAIT_BUSY) && !bus.spi_load) begin
          state_d = WAIT_DONE;
        end else if ((state_q == WAIT_DONE) && bus.spi_load) begin
          state_d = CAPTURE;
        end else if (wdog_expired) begin
          terr_d  = 1'b1;
          pop     = 1'b1;
          gap_d   = GAP_W'(GAP_CYCLES - 1);
          state_d = GAP;
        end
      end
      CAPTURE: begin
        rsp_data_d  = bus.spi_dout;
        rsp_valid_d = 1'b1;
        pop         = 1'b1;
        gap_d       = GAP_W'(GAP_CYCLES - 1);
        state_d     = GAP;
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wdog_q      <= '0;
      gap_q       <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      terr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wdog_q      <= wdog_d;
      gap_q       <= gap_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      terr_q      <= terr_d;
    end
  end
endmodule
